// File: rtl/mcx_pkg.sv
// Shared MCX definitions: accumulator word width, XBus arbiter states, and an
// elaboration-time clog2 helper.
package mcx_pkg;

  localparam int unsigned MCX_DATA_W = 11;

  typedef enum logic {
    XB_IDLE = 1'b0,
    XB_ACK  = 1'b1
  } xbus_state_t;

  function automatic int unsigned clog2(input int unsigned val);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < val) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/xbus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after i_ptr,
// searching cyclically.
module rr_pick
  import mcx_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt_c,
  output logic [IW-1:0] o_idx_c,
  output logic          o_any_c
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_pos;

  always_comb begin
    o_gnt_c = '0;
    o_idx_c = '0;
    o_any_c = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int k = 0; k < int'(N); k++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      w_pos = w_sum[IW-1:0];
      if (!o_any_c && i_req[w_pos]) begin
        o_gnt_c[w_pos] = 1'b1;
        o_idx_c        = w_pos;
        o_any_c        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xbus_arbiter.sv
// XBus arbiter: pairs one waiting writer with one waiting reader (round-robin on
// both sides) and moves one word per transfer. Optional request timeout: XBUS_TIMEOUT_EN.
module xbus_arbiter
  import mcx_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned DATA_W      = MCX_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [NUM_PORTS-1:0]          wr_req,
  input  logic [NUM_PORTS*DATA_W-1:0]   wr_data,
  input  logic [NUM_PORTS-1:0]          rd_req,
  output logic [NUM_PORTS-1:0]          wr_ack,
  output logic [NUM_PORTS-1:0]          rd_ack,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          busy,
  output logic [NUM_PORTS-1:0]          timeout
);

  localparam int unsigned IW = (clog2(NUM_PORTS) < 1) ? 1 : clog2(NUM_PORTS);

  xbus_state_t            r_state, w_next_state;
  logic [IW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [NUM_PORTS-1:0]   r_wr_ack, r_rd_ack;
  logic [DATA_W-1:0]      r_rd_data;
  logic                   r_busy;

  logic [NUM_PORTS-1:0]   w_wr_eff, w_rd_eff, w_elig_wr, w_rd_cand;
  logic [NUM_PORTS-1:0]   w_wr_gnt, w_rd_gnt;
  logic [IW-1:0]          w_wr_idx, w_rd_idx;
  logic                   w_wr_any, w_rd_any, w_grant;
  logic [DATA_W-1:0]      w_sel_data;

  // A writer is eligible only if some other core is reading.
  always_comb begin
    w_elig_wr = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++)
      w_elig_wr[i] = w_wr_eff[i] & (|(w_rd_eff & ~(NUM_PORTS'(1) << i)));
  end

  assign w_rd_cand = w_rd_eff & ~w_wr_gnt;

  rr_pick #(.N(NUM_PORTS), .IW(IW)) u_wr_pick (
    .i_req   (w_elig_wr),
    .i_ptr   (r_wr_ptr),
    .o_gnt_c (w_wr_gnt),
    .o_idx_c (w_wr_idx),
    .o_any_c (w_wr_any)
  );

  rr_pick #(.N(NUM_PORTS), .IW(IW)) u_rd_pick (
    .i_req   (w_rd_cand),
    .i_ptr   (r_rd_ptr),
    .o_gnt_c (w_rd_gnt),
    .o_idx_c (w_rd_idx),
    .o_any_c (w_rd_any)
  );

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++)
      if (w_wr_gnt[i]) w_sel_data = wr_data[i*DATA_W +: DATA_W];
  end

  // Next-state: ACK always lasts exactly one cycle.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    case (r_state)
      XB_IDLE: begin
        if (w_wr_any && w_rd_any) begin
          w_grant      = 1'b1;
          w_next_state = XB_ACK;
        end
      end
      XB_ACK:  w_next_state = XB_IDLE;
      default: w_next_state = XB_IDLE;
    endcase
  end

  // Acks are registered at the grant edge so they are visible during ACK.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= XB_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_wr_ack  <= '0;
      r_rd_ack  <= '0;
      r_rd_data <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_wr_ack  <= w_wr_gnt;
        r_rd_ack  <= w_rd_gnt;
        r_rd_data <= w_sel_data;
        r_busy    <= 1'b1;
        r_wr_ptr  <= (w_wr_idx == IW'(NUM_PORTS-1)) ? '0 : w_wr_idx + IW'(1);
        r_rd_ptr  <= (w_rd_idx == IW'(NUM_PORTS-1)) ? '0 : w_rd_idx + IW'(1);
      end else begin
        r_wr_ack <= '0;
        r_rd_ack <= '0;
        r_busy   <= 1'b0;
      end
    end
  end

  assign wr_ack  = r_wr_ack;
  assign rd_ack  = r_rd_ack;
  assign rd_data = r_rd_data;
  assign busy    = r_busy;

`ifdef XBUS_TIMEOUT_EN
  localparam int unsigned CW = (clog2(TIMEOUT_CYC+1) < 1) ? 1 : clog2(TIMEOUT_CYC+1);

  logic [CW-1:0]        r_wr_cnt [NUM_PORTS];
  logic [CW-1:0]        r_rd_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_wr_mask, r_rd_mask, r_timeout;
  logic [NUM_PORTS-1:0] w_wr_done, w_rd_done, w_wr_to, w_rd_to;

  // A request granted this edge or being acked is not waiting.
  assign w_wr_done = (w_grant ? w_wr_gnt : '0) | r_wr_ack;
  assign w_rd_done = (w_grant ? w_rd_gnt : '0) | r_rd_ack;

  always_comb begin
    w_wr_to = '0;
    w_rd_to = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      w_wr_to[i] = wr_req[i] & ~r_wr_mask[i] & ~w_wr_done[i] &
                   (r_wr_cnt[i] == CW'(TIMEOUT_CYC-1));
      w_rd_to[i] = rd_req[i] & ~r_rd_mask[i] & ~w_rd_done[i] &
                   (r_rd_cnt[i] == CW'(TIMEOUT_CYC-1));
    end
  end

  // Expired requests stay masked until the core drops req.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
        r_wr_cnt[i] <= '0;
        r_rd_cnt[i] <= '0;
      end
      r_wr_mask <= '0;
      r_rd_mask <= '0;
      r_timeout <= '0;
    end else begin
      r_timeout <= w_wr_to | w_rd_to;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
        if (!wr_req[i]) begin
          r_wr_cnt[i]  <= '0;
          r_wr_mask[i] <= 1'b0;
        end else if (w_wr_done[i]) begin
          r_wr_cnt[i]  <= '0;
        end else if (w_wr_to[i]) begin
          r_wr_cnt[i]  <= CW'(TIMEOUT_CYC);
          r_wr_mask[i] <= 1'b1;
        end else if (!r_wr_mask[i]) begin
          r_wr_cnt[i]  <= r_wr_cnt[i] + CW'(1);
        end
        if (!rd_req[i]) begin
          r_rd_cnt[i]  <= '0;
          r_rd_mask[i] <= 1'b0;
        end else if (w_rd_done[i]) begin
          r_rd_cnt[i]  <= '0;
        end else if (w_rd_to[i]) begin
          r_rd_cnt[i]  <= CW'(TIMEOUT_CYC);
          r_rd_mask[i] <= 1'b1;
        end else if (!r_rd_mask[i]) begin
          r_rd_cnt[i]  <= r_rd_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_wr_eff = wr_req & ~r_wr_mask;
  assign w_rd_eff = rd_req & ~r_rd_mask;
  assign timeout  = r_timeout;
`else
  assign w_wr_eff = wr_req;
  assign w_rd_eff = rd_req;
  assign timeout  = '0;
`endif

endmodule
